// File: rtl/csr_pkg.sv
// Shared CSR definitions: implemented addresses, mcountinhibit bit indices and the
// address decoder that folds read-only user aliases onto their machine-mode storage.
package csr_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

    localparam int MCOUNTINHIBIT_CY = 0;
    localparam int MCOUNTINHIBIT_IR = 2;
    localparam logic [31:0] MCOUNTINHIBIT_MASK =
        (32'd1 << MCOUNTINHIBIT_CY) | (32'd1 << MCOUNTINHIBIT_IR);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MCYCLE,
        SEL_MCYCLEH,
        SEL_MINSTRET,
        SEL_MINSTRETH,
        SEL_MCOUNTINHIBIT,
        SEL_MSCRATCH
    } csr_sel_t;

    // Aliases decode to the same selector as the storage they mirror.
    function automatic csr_sel_t csr_decode(input logic [11:0] addr);
        csr_sel_t sel;
        case (addr)
            CSR_MCYCLE,    CSR_CYCLE:    sel = SEL_MCYCLE;
            CSR_MCYCLEH,   CSR_CYCLEH:   sel = SEL_MCYCLEH;
            CSR_MINSTRET,  CSR_INSTRET:  sel = SEL_MINSTRET;
            CSR_MINSTRETH, CSR_INSTRETH: sel = SEL_MINSTRETH;
            CSR_MCOUNTINHIBIT:           sel = SEL_MCOUNTINHIBIT;
            CSR_MSCRATCH:                sel = SEL_MSCRATCH;
            default:                     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // The top two address bits equal to 2'b11 mark the read-only space.
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return (addr[11:10] == 2'b11);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter built from two 32-bit halves. A write to one half wins over the
// increment: low write drops the increment, high write keeps the low increment but drops its carry.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [31:0] lo;
    logic [31:0] hi;
    logic [32:0] lo_sum;

    assign lo_sum  = {1'b0, lo} + {32'd0, inc_i};
    assign count_o = {hi, lo};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lo <= '0;
            hi <= '0;
        end else if (wr_lo_i) begin
            lo <= wdata_i;
        end else if (wr_hi_i) begin
            hi <= wdata_i;
            lo <= lo_sum[31:0];
        end else begin
            lo <= lo_sum[31:0];
            hi <= hi + {31'd0, lo_sum[32]};
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR storage (cycle/instret counters, mcountinhibit, mscratch) with a
// combinational read port. Optional feature macro: CSR_WB_BYPASS_EN forwards a same-cycle write.
module csr_file
    import csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [11:0] csr_addr_e_i,
    output logic [31:0] csr_data_e_o,
    output logic        csr_illegal_e_o,
    input  logic        csr_we_w_i,
    input  logic [11:0] csr_addr_w_i,
    input  logic [31:0] csr_result_w_i,
    input  logic        retire_w_i
);

    csr_sel_t    sel_w;
    csr_sel_t    sel_e;
    logic        wr_ok;
    logic [31:0] mcountinhibit;
    logic [31:0] mscratch;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    assign sel_w = csr_decode(csr_addr_w_i);
    assign sel_e = csr_decode(csr_addr_e_i);
    // Writes through read-only aliases must not reach the shared storage.
    assign wr_ok = csr_we_w_i && !csr_is_ro(csr_addr_w_i);

    csr_counter64 u_cycle (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (!mcountinhibit[MCOUNTINHIBIT_CY]),
        .wr_lo_i   (wr_ok && (sel_w == SEL_MCYCLE)),
        .wr_hi_i   (wr_ok && (sel_w == SEL_MCYCLEH)),
        .wdata_i   (csr_result_w_i),
        .count_o   (mcycle)
    );

    csr_counter64 u_instret (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (retire_w_i && !mcountinhibit[MCOUNTINHIBIT_IR]),
        .wr_lo_i   (wr_ok && (sel_w == SEL_MINSTRET)),
        .wr_hi_i   (wr_ok && (sel_w == SEL_MINSTRETH)),
        .wdata_i   (csr_result_w_i),
        .count_o   (minstret)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mcountinhibit <= '0;
            mscratch      <= '0;
        end else if (wr_ok) begin
            if (sel_w == SEL_MCOUNTINHIBIT) mcountinhibit <= csr_result_w_i & MCOUNTINHIBIT_MASK;
            if (sel_w == SEL_MSCRATCH)      mscratch      <= csr_result_w_i;
        end
    end

    always_comb begin
        csr_data_e_o    = '0;
        csr_illegal_e_o = 1'b0;
        case (sel_e)
            SEL_MCYCLE:        csr_data_e_o = mcycle[31:0];
            SEL_MCYCLEH:       csr_data_e_o = mcycle[63:32];
            SEL_MINSTRET:      csr_data_e_o = minstret[31:0];
            SEL_MINSTRETH:     csr_data_e_o = minstret[63:32];
            SEL_MCOUNTINHIBIT: csr_data_e_o = mcountinhibit;
            SEL_MSCRATCH:      csr_data_e_o = mscratch;
            default:           csr_illegal_e_o = 1'b1;
        endcase
`ifdef CSR_WB_BYPASS_EN
        if (wr_ok && (sel_w == sel_e) && (sel_e != SEL_NONE)) begin
            csr_data_e_o = (sel_e == SEL_MCOUNTINHIBIT) ? (csr_result_w_i & MCOUNTINHIBIT_MASK)
                                                        : csr_result_w_i;
        end
`endif
    end

endmodule
